// File: rtl/clkdiv_prog.sv
// Programmable clock divider. New period/high-time settings wait in a shadow
// register and only take effect at a period boundary or while stopped.
module clkdiv_prog #(
  parameter int WIDTH      = 16,
  parameter int RESET_DIV  = 2,
  parameter int RESET_DUTY = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam int RST_P_I = (RESET_DIV < 2) ? 2 : RESET_DIV;
  localparam int RST_H_I = (RESET_DUTY == 0)       ? RST_P_I / 2 :
                           (RESET_DUTY >= RST_P_I) ? RST_P_I - 1 : RESET_DUTY;
  localparam logic [WIDTH-1:0] RST_P = WIDTH'(RST_P_I);
  localparam logic [WIDTH-1:0] RST_H = WIDTH'(RST_H_I);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] p_act, h_act;
  logic [WIDTH-1:0] p_sh, h_sh;
  logic [WIDTH-1:0] p_new, h_new;
  logic             last;
  logic             apply;

  // Clamp the requested divisor and resolve the duty so high time is 1..P-1.
  always_comb begin
    p_new = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
    if (duty_in == '0)
      h_new = p_new >> 1;
    else if (duty_in >= p_new)
      h_new = p_new - WIDTH'(1);
    else
      h_new = duty_in;
  end

  assign last  = (cnt == p_act - WIDTH'(1));
  assign apply = pending && (!en || last);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      p_act   <= RST_P;
      h_act   <= RST_H;
      p_sh    <= RST_P;
      h_sh    <= RST_H;
    end else begin
      if (en) begin
        cnt     <= last ? '0 : cnt + WIDTH'(1);
        clk_out <= (cnt < h_act);
        tick    <= last;
      end else begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end
      if (apply) begin
        p_act <= p_sh;
        h_act <= h_sh;
      end
      // A load on an apply edge moves the old shadow in and keeps the new one waiting.
      if (load) begin
        p_sh    <= p_new;
        h_sh    <= h_new;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/clkdiv_prog.md
CLKDIV_PROG -- requirements
Module: clkdiv_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of counter, divisor and duty values (legal range 2..32).
REQ-002 SHALL have parameter RESET_DIV, default 2, period in clk_in cycles after reset.
REQ-003 SHALL have parameter RESET_DUTY, default 0, high time in clk_in cycles after reset (0 = half period).
REQ-004 SHALL have port clk_in  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  run enable.
REQ-007 SHALL have port load  input  1  single-cycle strobe capturing div_in/duty_in.
REQ-008 SHALL have port div_in  input  WIDTH  requested period P in clk_in cycles.
REQ-009 SHALL have port duty_in  input  WIDTH  requested high time H in clk_in cycles.
REQ-010 SHALL have port clk_out  output  1  divided clock, registered.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on the last cycle of each period, registered.
REQ-012 SHALL have port pending  output  1  a loaded setting is waiting to take effect.

Function
REQ-013 SHALL hold an active setting (P_act, H_act), a shadow setting (P_sh, H_sh) and a WIDTH-bit counter cnt.
REQ-014 SHALL clamp divisor: value < 2 becomes 2; applied when captured into shadow.
REQ-015 SHALL resolve duty at capture: 0 gives floor(P/2); value >= P gives P-1; otherwise unchanged; result always 1..P-1.
REQ-016 SHALL, on an edge with load=1, write clamped values into shadow and set pending=1; a load while pending=1 overwrites the shadow (last load wins).
REQ-017 SHALL, on an edge with en=1: cnt <= (cnt==P_act-1) ? 0 : cnt+1; clk_out <= (cnt < H_act); tick <= (cnt == P_act-1).
REQ-018 SHALL give clk_out exactly P_act cycles per period, high for H_act cycles then low for P_act-H_act cycles; first high cycle follows the first edge with en=1.
REQ-019 SHALL apply the shadow only at a period boundary: on an edge with en=1, cnt==P_act-1 and pending=1, P_act<=P_sh, H_act<=H_sh, pending<=0; the current period completes with the old setting (no glitch, no truncated pulse).
REQ-020 SHALL, on an edge with en=0: cnt<=0, clk_out<=0, tick<=0; if pending=1, apply shadow to active and clear pending on that edge.
REQ-021 SHALL, when load=1 coincides with an apply edge, apply the old shadow and capture the new values, leaving pending=1.
REQ-022 SHALL restart from cnt=0 when en rises again; no partial period is resumed.
REQ-023 SHALL never change P_act/H_act other than by REQ-019/REQ-020 or reset.
REQ-024 SHALL ignore div_in/duty_in when load=0.

Reset
REQ-025 SHALL, while rst=1, immediately force cnt=0, clk_out=0, tick=0, pending=0, independent of clk_in.
REQ-026 SHALL on reset load active and shadow with RESET_DIV/RESET_DUTY after the clamp/resolve rules of REQ-014/REQ-015.
REQ-027 SHALL, on rst asserted mid-period, abandon the period and discard any pending setting; operation resumes from cnt=0 on the first edge after rst=0 with en=1.

Verification
REQ-028 Defaults, rst released, en=1 -> clk_out 1,0,1,0... (P=2,H=1); tick high every 2nd cycle coinciding with clk_out low.
REQ-029 load div_in=5 duty_in=0 while running -> pending=1 until current period ends, then clk_out high 2 / low 3 cycles; tick every 5 cycles; pending=0.
REQ-030 load div_in=1 duty_in=9 -> clamped P=2,H=1; load div_in=8 duty_in=8 -> H=7: high 7 / low 1.
REQ-031 Two loads (div 6 then div 10) within one period of P=12 -> only P=10 ever appears; no 6-cycle period; no short clk_out pulse at switch.
REQ-032 en dropped mid-high phase with pending=1 -> next edge clk_out=0, tick=0, setting applied, pending=0; en re-asserted -> full first period with new setting.
REQ-033 rst pulsed asynchronously (between clk_in edges) mid-period with pending=1 -> clk_out=0 and pending=0 without a clock edge; after release, RESET_DIV/RESET_DUTY pattern restarts from cnt=0.
